// File: rtl/toggle_cover_collector_pkg.sv
// Shared types and helpers for the cover_* coverage collectors.
// Point counts and index widths are derived here so every collector sizes its ports the same way.
package cover_pkg;

  typedef enum logic {
    LEVEL  = 1'b0,
    TOGGLE = 1'b1
  } cover_mode_e;

  // Matches the 64-bit longint on the DPI side.
  typedef logic [63:0] cover_idx_t;

  function automatic int npts(input int width, input int mode);
    return (mode != 0) ? 2 * width : width;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/toggle_cover_collector_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the next pending cover point.
module cover_prio_enc
  import cover_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  output logic          any,
  output logic [IW-1:0] idx
);

  // NOTE: every output gets a default before the loop; a path that leaves one unassigned infers a latch.
  always_comb begin
    any = 1'b0;
    idx = '0;
    // Scanning downward lets the lowest set bit overwrite the others.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/toggle_cover_collector.sv
// Toggle/level coverage collector: latches first hits in a sticky bitmap and reports each
// newly hit point once per clear epoch, lowest index first, over a valid/ready port.
module toggle_cover_collector
  import cover_pkg::*;
#(
  parameter  int         WIDTH       = 29,
  parameter  int         MODE        = 1,
  parameter  cover_idx_t COVER_INDEX = '0,
  parameter  cover_idx_t COVER_TOTAL = 64'd8065,
  localparam int         NPTS        = npts(WIDTH, MODE),
  localparam int         CW          = $clog2(NPTS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] sample,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output cover_idx_t       rpt_index,
  output logic [CW-1:0]    covered_count,
  output logic             all_covered
);

  localparam int  IW        = idx_w(NPTS);
  localparam bit  IS_TOGGLE = (MODE == int'(TOGGLE));

  if (COVER_INDEX + cover_idx_t'(NPTS) > COVER_TOTAL) begin : g_range_check
    $error("toggle_cover_collector: COVER_INDEX + NPTS exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             primed_q, primed_d;
  logic [NPTS-1:0]  hit_q, hit_d;
  logic [NPTS-1:0]  pend_q, pend_d;
  logic             valid_q, valid_d;
  cover_idx_t       index_q, index_d;
  logic [CW-1:0]    count_q, count_d;

  logic [NPTS-1:0]  ev;
  logic [NPTS-1:0]  new_pts;
  logic             enc_any;
  logic [IW-1:0]    enc_idx;
  logic             load;
  logic             handshake;

  if (IS_TOGGLE) begin : g_toggle
    // Rise of bit i is point 2i, fall is 2i+1; nothing fires until prev holds a real sample.
    always_comb begin
      ev = '0;
      for (int i = 0; i < WIDTH; i++) begin
        ev[2*i]   = enable & primed_q &  sample[i] & ~prev_q[i];
        ev[2*i+1] = enable & primed_q & ~sample[i] &  prev_q[i];
      end
    end
  end else begin : g_level
    assign ev = {WIDTH{enable}} & sample;
  end

  assign new_pts = ev & ~hit_q;

  cover_prio_enc #(.N(NPTS)) u_enc (
    .req (pend_q),
    .any (enc_any),
    .idx (enc_idx)
  );

  assign handshake = valid_q & rpt_ready;
  assign load      = (~valid_q | rpt_ready) & enc_any;

  always_comb begin
    prev_d   = enable ? sample : prev_q;
    primed_d = primed_q | enable;
    hit_d    = hit_q | new_pts;
    pend_d   = pend_q | new_pts;
    valid_d  = valid_q;
    index_d  = index_q;
    count_d  = count_q;

    if (load) begin
      pend_d[enc_idx] = 1'b0;
      valid_d         = 1'b1;
      index_d         = COVER_INDEX + cover_idx_t'(enc_idx);
    end else if (rpt_ready) begin
      valid_d = 1'b0;
    end

    if (handshake && count_q != CW'(NPTS)) begin
      count_d = count_q + 1'b1;
    end

    // Restarting the epoch discards this cycle's events and handshake.
    if (clear) begin
      primed_d = 1'b0;
      hit_d    = '0;
      pend_d   = '0;
      valid_d  = 1'b0;
      count_d  = '0;
    end
  end

  // NOTE: the bitmaps are plain flops rather than a RAM, so they reset along with everything else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: state updates use <= so every register samples the pre-edge values of its peers.
      prev_q   <= '0;
      primed_q <= 1'b0;
      hit_q    <= '0;
      pend_q   <= '0;
      valid_q  <= 1'b0;
      index_q  <= '0;
      count_q  <= '0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      hit_q    <= hit_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      index_q  <= index_d;
      count_q  <= count_d;
    end
  end

  assign rpt_valid     = valid_q;
  assign rpt_index     = index_q;
  assign covered_count = count_q;
  assign all_covered   = (count_q == CW'(NPTS));

endmodule

`ifndef SYNTHESIS
`ifdef DIFFTEST
// Difftest sink: always ready, presents every accepted report to the coverage hook.
module toggle_cover_collector_dpi_sink
  import cover_pkg::*;
#(
  parameter int         WIDTH       = 29,
  parameter int         MODE        = 1,
  parameter cover_idx_t COVER_INDEX = '0,
  parameter cover_idx_t COVER_TOTAL = 64'd8065
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] sample,
  output logic             cover_fire,
  output cover_idx_t       cover_index
);

  logic                                   rpt_valid;
  cover_idx_t                             rpt_index;
  logic [$clog2(npts(WIDTH, MODE)+1)-1:0] covered_count;
  logic                                   all_covered;

  toggle_cover_collector #(
    .WIDTH       (WIDTH),
    .MODE        (MODE),
    .COVER_INDEX (COVER_INDEX),
    .COVER_TOTAL (COVER_TOTAL)
  ) u_collector (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .clear         (clear),
    .sample        (sample),
    .rpt_valid     (rpt_valid),
    .rpt_ready     (1'b1),
    .rpt_index     (rpt_index),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  assign cover_fire  = reset & rpt_valid;
  assign cover_index = rpt_index;

endmodule
`endif
`endif

// File: tb/tb_toggle_cover_collector.sv
// Directed bench for toggle_cover_collector: a toggle-mode instance driven from a vector
// table plus hand sequences for clear/reset, and a level-mode instance for the sticky-hit case.
module tb_toggle_cover_collector;
  import cover_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       t_en, t_clr, t_rdy, t_valid, t_all;
  logic [3:0] t_smp;
  cover_idx_t t_idx;
  logic [3:0] t_cnt;

  logic        l_en, l_clr, l_rdy, l_valid, l_all;
  logic [28:0] l_smp;
  cover_idx_t  l_idx;
  logic [4:0]  l_cnt;

  toggle_cover_collector #(
    .WIDTH(4), .MODE(1), .COVER_INDEX(64'd100), .COVER_TOTAL(64'd8065)
  ) dut_t (
    .clock(clk), .reset(rst_n), .enable(t_en), .clear(t_clr), .sample(t_smp),
    .rpt_valid(t_valid), .rpt_ready(t_rdy), .rpt_index(t_idx),
    .covered_count(t_cnt), .all_covered(t_all)
  );

  toggle_cover_collector #(
    .WIDTH(29), .MODE(0), .COVER_INDEX(64'd7000), .COVER_TOTAL(64'd8065)
  ) dut_l (
    .clock(clk), .reset(rst_n), .enable(l_en), .clear(l_clr), .sample(l_smp),
    .rpt_valid(l_valid), .rpt_ready(l_rdy), .rpt_index(l_idx),
    .covered_count(l_cnt), .all_covered(l_all)
  );

  typedef struct {
    logic       en, clr, rdy;
    logic [3:0] smp;
    logic       v;
    cover_idx_t idx;
    logic [3:0] cnt;
    logic       all;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic en, input logic clr, input logic [3:0] smp, input logic rdy,
                     input logic v, input int idx, input int cnt, input logic all);
    vec_t r;
    r.en = en; r.clr = clr; r.smp = smp; r.rdy = rdy;
    r.v = v; r.idx = cover_idx_t'(idx); r.cnt = 4'(cnt); r.all = all;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input cover_idx_t act, input cover_idx_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_t(input string tag, input logic v, input int idx, input int cnt,
                         input logic all);
    check({tag, ".valid"}, cover_idx_t'(t_valid), cover_idx_t'(v));
    check({tag, ".index"}, t_idx, cover_idx_t'(idx));
    check({tag, ".count"}, cover_idx_t'(t_cnt), cover_idx_t'(cnt));
    check({tag, ".all"},   cover_idx_t'(t_all), cover_idx_t'(all));
  endtask

  task automatic drive_t(input logic en, input logic clr, input logic [3:0] smp, input logic rdy);
    t_en = en; t_clr = clr; t_smp = smp; t_rdy = rdy;
  endtask

  int          n_rep;
  cover_idx_t  last_idx;

  initial begin
    rst_n = 1'b0;
    drive_t(1'b0, 1'b0, 4'b0000, 1'b1);
    l_en = 1'b0; l_clr = 1'b0; l_smp = '0; l_rdy = 1'b1;

    // Toggle-mode reference table: {enable, clear, sample, ready} -> {valid, index, count, all}.
    add(1, 0, 4'b1111, 1,  0,   0, 0, 0);  // first sample only primes
    add(1, 0, 4'b0000, 1,  0,   0, 0, 0);  // four falls latched
    add(1, 0, 4'b0000, 1,  1, 101, 0, 0);
    add(1, 0, 4'b0000, 1,  1, 103, 1, 0);
    add(1, 0, 4'b0000, 1,  1, 105, 2, 0);
    add(1, 0, 4'b0000, 1,  1, 107, 3, 0);
    add(1, 0, 4'b0000, 1,  0, 107, 4, 0);
    add(1, 0, 4'b1111, 1,  0, 107, 4, 0);  // four rises latched
    add(1, 0, 4'b1111, 1,  1, 100, 4, 0);
    add(1, 0, 4'b1111, 1,  1, 102, 5, 0);
    add(1, 0, 4'b1111, 1,  1, 104, 6, 0);
    add(1, 0, 4'b1111, 1,  1, 106, 7, 0);
    add(1, 0, 4'b1111, 1,  0, 106, 8, 1);
    add(1, 0, 4'b0000, 1,  0, 106, 8, 1);  // already hit: ignored
    add(1, 0, 4'b1111, 1,  0, 106, 8, 1);
    add(1, 1, 4'b0000, 1,  0, 106, 0, 0);  // new epoch
    add(1, 0, 4'b0000, 0,  0, 106, 0, 0);  // primes; ready low from here for 10 cycles
    add(1, 0, 4'b1001, 0,  0, 106, 0, 0);  // bits 0 and 3 rise
    for (int i = 0; i < 8; i++) add(1, 0, 4'b1001, 0,  1, 100, 0, 0);
    add(1, 0, 4'b1001, 1,  1, 106, 1, 0);
    add(1, 0, 4'b1001, 1,  0, 106, 2, 0);
    add(1, 0, 4'b1001, 1,  0, 106, 2, 0);
    add(0, 0, 4'b0000, 1,  0, 106, 2, 0);  // disabled: no event, prev holds 1001
    add(1, 0, 4'b1001, 1,  0, 106, 2, 0);

    #1;
    check_t("reset", 1'b0, 0, 0, 1'b0);
    check("reset.l_valid", cover_idx_t'(l_valid), '0);
    check("reset.l_count", cover_idx_t'(l_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive_t(vecs[i].en, vecs[i].clr, vecs[i].smp, vecs[i].rdy);
      tick();
      check_t($sformatf("v%0d", i), vecs[i].v, int'(vecs[i].idx), int'(vecs[i].cnt),
              vecs[i].all);
    end

    // Clear in the same cycle as a bit-0 rise, with report 101 held under backpressure.
    drive_t(1, 0, 4'b0000, 0); tick(); check_t("clr.pend", 0, 106, 2, 0);
    tick();                            check_t("clr.held", 1, 101, 2, 0);
    drive_t(1, 1, 4'b0001, 0); tick(); check_t("clr.hit",  0, 101, 0, 0);
    drive_t(1, 0, 4'b0001, 1); tick(); check_t("clr.prime", 0, 101, 0, 0);
    tick();                            check_t("clr.idle", 0, 101, 0, 0);
    drive_t(1, 0, 4'b0000, 1); tick(); check_t("clr.fall", 0, 101, 0, 0);
    tick();                            check_t("clr.rerpt", 1, 101, 0, 0);
    tick();                            check_t("clr.count", 0, 101, 1, 0);

    // Asynchronous reset while a report is presented.
    drive_t(1, 0, 4'b0001, 0); tick(); check_t("rst.pend", 0, 101, 1, 0);
    tick();                            check_t("rst.valid", 1, 100, 1, 0);
    #2 rst_n = 1'b0;
    #1 check_t("rst.async", 0, 0, 0, 0);
    drive_t(1, 0, 4'b0001, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();                            check_t("rst.prime", 0, 0, 0, 0);
    tick();                            check_t("rst.quiet", 0, 0, 0, 0);
    drive_t(1, 0, 4'b0000, 1); tick(); check_t("rst.fall", 0, 0, 0, 0);
    tick();                            check_t("rst.rpt", 1, 101, 0, 0);
    drive_t(0, 0, 4'b0000, 1);

    // Level mode: a bit held high for 50 cycles is reported exactly once.
    l_en  = 1'b1;
    l_smp = 29'h1000_0000;
    n_rep = 0;
    last_idx = '0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (l_valid) begin
        n_rep++;
        last_idx = l_idx;
      end
    end
    l_smp = '0;
    tick();
    check("lvl.reports", cover_idx_t'(n_rep), 64'd1);
    check("lvl.index",   last_idx, 64'd7028);
    check("lvl.count",   cover_idx_t'(l_cnt), 64'd1);
    check("lvl.all",     cover_idx_t'(l_all), 64'd0);
    check("lvl.valid",   cover_idx_t'(l_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/toggle_cover_collector.md
# toggle_cover_collector

Parametrised toggle-coverage collector for the formal/fuzzing coverage flow. Watches a WIDTH-bit signal vector and records each coverage point the first time it is hit in a sticky bitmap. It queues newly hit points and reports them one at a time, as absolute cover indices, on a valid/ready port. The port is drained by the DPI sink that calls v_cover_toggle, so each point is reported once per clear epoch rather than every cycle.

## Interface
- WIDTH, 29: number of monitored signal bits.
- MODE, 1: 0 = level mode, one point per bit, hit when the bit is 1. 1 = toggle mode, two points per bit: rise and fall.
- COVER_INDEX, 0: absolute index of this instance's point 0.
- COVER_TOTAL, 8065: total points in the design; used only for the elaboration check below.
- Derived NPTS = WIDTH×(MODE?2:1); CW = $clog2(NPTS+1).

Ports:
- clock  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  sample qualifier; no event is detected while low.
- clear  in  1  synchronous restart of the coverage epoch.
- sample  in  WIDTH  monitored signals.
- rpt_valid  out  1  a report is presented.
- rpt_ready  in  1  the sink accepts the report.
- rpt_index  out  64  COVER_INDEX + point number.
- covered_count  out  CW  number of points reported this epoch.
- all_covered  out  1  high when covered_count == NPTS.

## Operation
- State registers:
  - prev[WIDTH]: previous sample.
  - primed: 1 once prev holds a valid sample.
  - hit[NPTS]: sticky first-hit bitmap.
  - pend[NPTS]: points hit but not yet loaded into the output register.
  - Output register: rpt_valid and rpt_index.
  - covered_count.
- Point numbering:
  - Level mode: bit i is point i.
  - Toggle mode: rise of bit i is point 2i; fall of bit i is point 2i+1.
- Event detection:
  - Level mode: ev[i] = enable & sample[i].
  - Toggle mode: rise = enable & primed & sample & ~prev; fall = enable & primed & ~sample & prev.
- new = ev & ~hit. On the clock edge: hit |= new and pend |= new.
- Each point enters pend at most once per epoch.
- prev loads sample whenever enable is high, and primed then sets. While enable is low, prev and primed hold.
- Priority-encode pend, lowest index first. Output-register load:
  - Load condition: (!rpt_valid || rpt_ready) and pend is non-zero.
  - On load: rpt_index ← COVER_INDEX + p, where p is the encoded point, clear pend[p], rpt_valid ← 1.
  - If the load condition holds but pend is zero and rpt_ready is high, rpt_valid ← 0.
- covered_count increments by 1 on each handshake (rpt_valid & rpt_ready). It saturates at NPTS.
- clear, synchronous: zero hit, pend, covered_count, rpt_valid and primed.
  - clear has priority over events and handshakes in the same cycle; those are discarded and not counted.
- Elaboration error if COVER_INDEX + NPTS > COVER_TOTAL.

## Timing
- Reset values: rpt_valid=0, rpt_index=0, covered_count=0, all_covered=0, primed=0, hit=0, pend=0, prev=0.
- Reset takes effect immediately on assertion, including mid-handshake; the in-flight report is lost.
- Latency: an event sampled at edge k sets pend at edge k. rpt_valid is high from edge k+1 at the earliest.
- Throughput: one report per cycle while rpt_ready is held high.
- Handshake:
  - rpt_index is stable while rpt_valid=1 and rpt_ready=0.
  - rpt_valid never drops without a handshake, except on clear or reset.
- Backpressure loses nothing; pend holds up to NPTS outstanding points.
- Toggle mode ignores the first enabled sample after reset or clear; it only primes prev.
- Simultaneous rise on many bits: all are latched in the same edge, then reported in ascending index order.
- An event on a point already in hit is ignored, whether the point is pending or already reported.
- all_covered is combinational from covered_count.

## Structure
- cover_pkg holds the shared items used by every cover_* collector:
  - cover_mode_e: LEVEL=0, TOGGLE=1.
  - cover_idx_t: logic [63:0], matching the DPI longint.
  - Helper function npts(width, mode).
- One sub-module, cover_prio_enc #(N): combinational lowest-set-bit encoder with outputs any and idx[$clog2(N)-1:0].
- Under `ifndef SYNTHESIS / `ifdef DIFFTEST, a thin sink ties rpt_ready=1 and calls v_cover_toggle(rpt_index) on each handshake.

## Test plan
- Reset release with WIDTH=4, MODE=1, COVER_INDEX=100, rpt_ready=1, first sample 4'b1111 → no report. Next sample 4'b0000 → reports 101, 103, 105, 107 on consecutive cycles; covered_count=4.
- Follow with sample 4'b1111 → reports 100, 102, 104, 106. covered_count=8 and all_covered=1. Any further toggling → no reports.
- rpt_ready=0 for 10 cycles while bits 0 and 3 rise → rpt_valid=1 holding index 100 stable. On release, reports 100 then 106; no loss and no duplicates.
- MODE=0, WIDTH=29, COVER_INDEX=7000, sample[28] held high for 50 cycles → exactly one report, index 7028.
- clear asserted in the same cycle as a bit-0 rise with a pending report → all state is zeroed and no report is issued. A subsequent toggle is re-reported; covered_count restarts at 1.
- reset asserted while rpt_valid=1 → rpt_valid=0 asynchronously, before the next edge. After release, the first toggle sample primes only.
